// File: rtl/mic_playback_dma.sv
// Avalon-MM read master that streams stereo sample words from memory into a
// small FIFO and hands one word to the codec on every DAC LRCK falling edge.
module mic_playback_dma #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] AM_ADDR,
  output logic        AM_READ,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic [3:0]  AM_BYTEENABLE,
  input  logic [31:0] AM_READDATA,
  input  logic        AM_READDATAVALID,
  input  logic        AM_WAITREQUEST,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [1:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  input  logic        AUD_DACLRCK,
  output logic [31:0] codec_out,
  output logic        underrun_pulse,
  output logic [2:0]  state_dbg_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_DRAIN     = 3'd3,
    S_FLUSH     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   start_addr_q, start_addr_d, num_samps_q, num_samps_d;
  logic [31:0]   addr_q, addr_d, fetch_left_q, fetch_left_d;
  logic [31:0]   played_q, played_d, codec_q, codec_d;
  logic          fin_q, fin_d, busy_q, busy_d, sticky_q, sticky_d;
  logic          underrun_q, underrun_d, pending_q, pending_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          s1_q, s2_q, s3_q;
  logic          fall, reg_wr, start, abort, accept, push, pop, clear;

  assign fall   = s3_q & ~s2_q;
  assign reg_wr = AVL_CS && AVL_WRITE;
  assign start  = reg_wr && (AVL_ADDR == 2'd0) && AVL_WRITEDATA[0];
  assign abort  = reg_wr && (AVL_ADDR == 2'd0) && AVL_WRITEDATA[1];
  assign accept = AM_READ && !AM_WAITREQUEST;

  // Request only while the FIFO has room; room can only grow while waiting,
  // so a raised request stays raised until accepted.
  assign AM_READ        = (state_q == S_ISSUE) && (count_q < DEPTH_C);
  assign AM_ADDR        = addr_q;
  assign AM_BURSTCOUNT  = 3'd1;
  assign AM_BYTEENABLE  = 4'hF;
  assign codec_out      = codec_q;
  assign underrun_pulse = underrun_q;
  assign state_dbg_o    = state_q;

  always_comb begin
    AVL_READDATA = 32'd0;
    if (AVL_CS && AVL_READ) begin
      case (AVL_ADDR)
        2'd0:    AVL_READDATA = {29'd0, sticky_q, busy_q, fin_q};
        2'd1:    AVL_READDATA = start_addr_q;
        2'd2:    AVL_READDATA = num_samps_q;
        default: AVL_READDATA = played_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    num_samps_d  = num_samps_q;
    addr_d       = addr_q;
    fetch_left_d = fetch_left_q;
    played_d     = played_q;
    codec_d      = codec_q;
    fin_d        = fin_q;
    busy_d       = busy_q;
    sticky_d     = sticky_q;
    pending_d    = pending_q;
    underrun_d   = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;

    if (reg_wr) begin
      case (AVL_ADDR)
        2'd1:    start_addr_d = AVL_WRITEDATA;
        2'd2:    num_samps_d  = AVL_WRITEDATA;
        2'd3:    sticky_d     = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_samps_q != 32'd0) begin
            addr_d       = start_addr_q;
            fetch_left_d = num_samps_q;
            played_d     = 32'd0;
            fin_d        = 1'b0;
            busy_d       = 1'b1;
            state_d      = S_ISSUE;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d       = addr_q + 32'd4;
          fetch_left_d = fetch_left_q - 32'd1;
          pending_d    = 1'b1;
          state_d      = abort ? S_FLUSH : S_WAIT_DATA;
        end else if (abort) begin
          state_d = S_FLUSH;
        end
      end
      S_WAIT_DATA: begin
        if (AM_READDATAVALID) pending_d = 1'b0;
        if (abort) begin
          state_d = S_FLUSH;
        end else if (AM_READDATAVALID) begin
          push    = 1'b1;
          state_d = (fetch_left_q != 32'd0) ? S_ISSUE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_FLUSH;
        end else if (played_q == num_samps_q) begin
          fin_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        // An outstanding read must return before the FIFO can be declared empty.
        if (!pending_q || AM_READDATAVALID) begin
          clear     = 1'b1;
          pending_d = 1'b0;
          busy_d    = 1'b0;
          fin_d     = 1'b0;
          codec_d   = 32'd0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fall && busy_q && (state_q != S_FLUSH)) begin
      if (count_q != '0) begin
        pop      = 1'b1;
        codec_d  = mem_q[rd_ptr_q];
        played_d = played_q + 32'd1;
      end else if (played_q < num_samps_q) begin
        codec_d    = 32'd0;
        underrun_d = 1'b1;
        sticky_d   = 1'b1;
      end
    end else if (fall && !busy_q) begin
      codec_d = 32'd0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      start_addr_q <= 32'd0;
      num_samps_q  <= 32'd0;
      addr_q       <= 32'd0;
      fetch_left_q <= 32'd0;
      played_q     <= 32'd0;
      codec_q      <= 32'd0;
      fin_q        <= 1'b0;
      busy_q       <= 1'b0;
      sticky_q     <= 1'b0;
      underrun_q   <= 1'b0;
      pending_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      num_samps_q  <= num_samps_d;
      addr_q       <= addr_d;
      fetch_left_q <= fetch_left_d;
      played_q     <= played_d;
      codec_q      <= codec_d;
      fin_q        <= fin_d;
      busy_q       <= busy_d;
      sticky_q     <= sticky_d;
      underrun_q   <= underrun_d;
      pending_q    <= pending_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      s1_q         <= AUD_DACLRCK;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= AM_READDATA;
  end
endmodule

// File: tb/tb_mic_playback_dma.sv
// Directed bench for mic_playback_dma: a behavioural Avalon slave with
// programmable latency/stall, an LRCK driver, and an expected-word queue.
module tb_mic_playback_dma;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] AM_ADDR;
  logic        AM_READ;
  logic [2:0]  AM_BURSTCOUNT;
  logic [3:0]  AM_BYTEENABLE;
  logic [31:0] AM_READDATA = 32'd0;
  logic        AM_READDATAVALID = 1'b0;
  logic        AM_WAITREQUEST = 1'b0;
  logic        AVL_CS = 1'b0;
  logic        AVL_READ = 1'b0;
  logic        AVL_WRITE = 1'b0;
  logic [1:0]  AVL_ADDR = 2'd0;
  logic [31:0] AVL_WRITEDATA = 32'd0;
  logic [31:0] AVL_READDATA;
  logic        AUD_DACLRCK = 1'b1;
  logic [31:0] codec_out;
  logic        underrun_pulse;
  logic [2:0]  dbg_state;

  mic_playback_dma #(.FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .AM_ADDR(AM_ADDR), .AM_READ(AM_READ), .AM_BURSTCOUNT(AM_BURSTCOUNT),
    .AM_BYTEENABLE(AM_BYTEENABLE), .AM_READDATA(AM_READDATA),
    .AM_READDATAVALID(AM_READDATAVALID), .AM_WAITREQUEST(AM_WAITREQUEST),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AUD_DACLRCK(AUD_DACLRCK), .codec_out(codec_out),
    .underrun_pulse(underrun_pulse), .state_dbg_o(dbg_state)
  );

  // Clock: 10 time-unit period.
  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];
  int          acc_cnt = 0;
  int          up_cnt = 0;
  int          lat = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = 32'd0;
  int          stall_at = -1;
  int          stall_len = 5;
  int          stall_cnt = 0;
  int          stall_bad = 0;
  int          stall_drop = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0001 + ((a - 32'h0000_1000) >> 2);
  endfunction

  // Behavioural memory slave: decides stall/response at the falling edge so
  // every value is stable at the next rising edge.
  always @(negedge CLK) begin
    AM_READDATAVALID = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        AM_READDATAVALID = 1'b1;
        AM_READDATA      = rsp_data;
      end
    end
    AM_WAITREQUEST = 1'b0;
    if (AM_READ && acc_cnt == stall_at && stall_cnt < stall_len) begin
      AM_WAITREQUEST = 1'b1;
      stall_cnt++;
      if (AM_ADDR !== 32'h0000_1004) stall_bad++;
    end else if (acc_cnt == stall_at && stall_cnt > 0 && !AM_READ) begin
      stall_drop++;
    end
    if (AM_READ && !AM_WAITREQUEST && !RESET) begin
      addr_log.push_back(AM_ADDR);
      acc_cnt++;
      rsp_cnt  = lat;
      rsp_data = mem_word(AM_ADDR);
    end
  end

  always @(negedge CLK) if (underrun_pulse) up_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    #1 d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic reg_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    avl_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One LRCK period; the codec word is checked against the expected queue.
  task automatic play_frame(input string tag);
    logic [31:0] e;
    @(negedge CLK);
    AUD_DACLRCK = 1'b0;
    cycles(8);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, codec_out, e);
    AUD_DACLRCK = 1'b1;
    cycles(8);
  endtask

  task automatic run_job(input logic [31:0] base, input logic [31:0] n);
    avl_write(2'd1, base);
    avl_write(2'd2, n);
    avl_write(2'd0, 32'd1);
  endtask

  initial begin
    int base_acc, base_up;

    // Reset state
    cycles(3);
    check("rst_am_read", {31'd0, AM_READ}, 32'd0);
    check("rst_am_addr", AM_ADDR, 32'd0);
    check("rst_codec", codec_out, 32'd0);
    check("rst_underrun", {31'd0, underrun_pulse}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    check("fixed_burst", {29'd0, AM_BURSTCOUNT}, 32'd1);
    check("fixed_be", {28'd0, AM_BYTEENABLE}, 32'hF);
    reg_check("rst_reg0", 2'd0, 32'd0);
    reg_check("rst_reg3", 2'd3, 32'd0);

    // Basic 4-sample playback, zero-wait slave
    base_acc = acc_cnt; base_up = up_cnt;
    run_job(32'h1000, 32'd4);
    check("first_read_req", {31'd0, AM_READ}, 32'd1);
    check("first_read_addr", AM_ADDR, 32'h1000);
    check("busy_state", {29'd0, dbg_state}, 32'd1);
    reg_check("reg1_rb", 2'd1, 32'h1000);
    cycles(30);
    check("t1_reads", acc_cnt - base_acc, 32'd4);
    for (int i = 0; i < 4; i++)
      check("t1_addr", addr_log[base_acc + i], 32'h1000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) exp_q.push_back(mem_word(32'h1000 + 32'(4 * i)));
    for (int i = 0; i < 4; i++) play_frame("t1_codec");
    reg_check("t1_reg0_fin", 2'd0, 32'd1);
    reg_check("t1_played", 2'd3, 32'd4);
    check("t1_underruns", up_cnt - base_up, 32'd0);

    // Waitrequest held for 5 cycles on the second read
    base_acc = acc_cnt;
    stall_at = acc_cnt + 1;
    run_job(32'h1000, 32'd4);
    cycles(40);
    check("t2_reads", acc_cnt - base_acc, 32'd4);
    check("t2_stall_cycles", stall_cnt, 32'd5);
    check("t2_stall_addr", stall_bad, 32'd0);
    check("t2_stall_drop", stall_drop, 32'd0);
    for (int i = 0; i < 4; i++)
      check("t2_addr", addr_log[base_acc + i], 32'h1000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) exp_q.push_back(mem_word(32'h1000 + 32'(4 * i)));
    for (int i = 0; i < 4; i++) play_frame("t2_codec");

    // FIFO fills with LRCK stopped, then drains and refills
    base_acc = acc_cnt; base_up = up_cnt;
    run_job(32'h1000, 32'd20);
    cycles(60);
    check("t3_fill_reads", acc_cnt - base_acc, 32'd8);
    check("t3_full_no_req", {31'd0, AM_READ}, 32'd0);
    check("t3_full_state", {29'd0, dbg_state}, 32'd1);
    for (int i = 0; i < 20; i++) exp_q.push_back(mem_word(32'h1000 + 32'(4 * i)));
    for (int i = 0; i < 20; i++) play_frame("t3_codec");
    check("t3_total_reads", acc_cnt - base_acc, 32'd20);
    reg_check("t3_played", 2'd3, 32'd20);
    reg_check("t3_reg0_fin", 2'd0, 32'd1);
    check("t3_underruns", up_cnt - base_up, 32'd0);

    // Slow slave: starved frame underruns, sticky flag and its clear
    base_up = up_cnt;
    lat = 2000;
    run_job(32'h1000, 32'd3);
    exp_q.push_back(32'd0);
    play_frame("t4_starved_codec");
    check("t4_underrun_pulses", up_cnt - base_up, 32'd1);
    reg_check("t4_reg0_sticky", 2'd0, 32'd6);
    avl_write(2'd3, 32'h1234_5678);
    reg_check("t4_reg0_cleared", 2'd0, 32'd2);
    lat = 20;
    cycles(2100);
    for (int i = 0; i < 3; i++) exp_q.push_back(mem_word(32'h1000 + 32'(4 * i)));
    for (int i = 0; i < 3; i++) play_frame("t4_codec");
    reg_check("t4_reg0_fin", 2'd0, 32'd1);
    check("t4_underruns_total", up_cnt - base_up, 32'd1);

    // Abort with a read outstanding
    base_acc = acc_cnt;
    lat = 50;
    run_job(32'h1000, 32'd4);
    cycles(5);
    check("t5_wait_state", {29'd0, dbg_state}, 32'd2);
    avl_write(2'd0, 32'd2);
    check("t5_flush_state", {29'd0, dbg_state}, 32'd4);
    cycles(60);
    check("t5_idle_state", {29'd0, dbg_state}, 32'd0);
    reg_check("t5_reg0", 2'd0, 32'd0);
    check("t5_codec", codec_out, 32'd0);
    check("t5_reads", acc_cnt - base_acc, 32'd1);

    // num_samps = 0: no fetch, fin next cycle
    lat = 1;
    base_acc = acc_cnt;
    avl_write(2'd2, 32'd0);
    avl_write(2'd0, 32'd1);
    check("t6_no_req", {31'd0, AM_READ}, 32'd0);
    reg_check("t6_fin", 2'd0, 32'd1);
    cycles(10);
    check("t6_reads", acc_cnt - base_acc, 32'd0);

    // Restart after abort plays fresh data only
    run_job(32'h2000, 32'd2);
    cycles(20);
    exp_q.push_back(32'hA000_0401);
    exp_q.push_back(32'hA000_0402);
    play_frame("t7_codec");
    play_frame("t7_codec");
    reg_check("t7_fin", 2'd0, 32'd1);
    reg_check("t7_played", 2'd3, 32'd2);

    // Reset in the middle of a transfer
    run_job(32'h1000, 32'd20);
    cycles(40);
    exp_q.push_back(32'hA000_0001);
    play_frame("t8_pre_codec");
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("t8_am_read", {31'd0, AM_READ}, 32'd0);
    check("t8_am_addr", AM_ADDR, 32'd0);
    check("t8_codec", codec_out, 32'd0);
    check("t8_state", {29'd0, dbg_state}, 32'd0);
    reg_check("t8_reg0", 2'd0, 32'd0);
    reg_check("t8_reg2", 2'd2, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    cycles(10);
    check("t8_post_req", {31'd0, AM_READ}, 32'd0);
    check("t8_post_state", {29'd0, dbg_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
